// File: rtl/board_stream_out.sv
// board_stream_out: streams a packed 64-square board as one beat per square
// over a valid/ready interface, row-major from square 0 (a1) to 63 (h8).
//
// Optional feature: define BOARD_STREAM_SKIP_EMPTY_EN to pass over empty
// squares (code 0) without emitting a beat; out_last then marks the final
// occupied square.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   board_in   packed board, square i at [i*PIECE_WIDTH +: PIECE_WIDTH]
//   load       start request, accepted only in IDLE
//   busy       high from the cycle after an accepted load through the done pulse
//   out_valid  beat valid
//   out_ready  sink accepts beat
//   out_row    row of the beat (0 = white back rank)
//   out_col    column of the beat (0 = a-file)
//   out_piece  square code of the beat
//   out_last   final beat of the board
//   done       one-cycle pulse when the stream completes

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef WHITE_PAWN
`define WHITE_PAWN   1
`define WHITE_KNIGHT 2
`define WHITE_BISHOP 3
`define WHITE_ROOK   4
`define WHITE_QUEEN  5
`define WHITE_KING   6
`define BLACK_PAWN   9
`define BLACK_KNIGHT 10
`define BLACK_BISHOP 11
`define BLACK_ROOK   12
`define BLACK_QUEEN  13
`define BLACK_KING   14
`endif

module board_stream_out #(
    parameter int unsigned PIECE_WIDTH = `PIECE_BITS,
    parameter int unsigned BOARD_WIDTH = PIECE_WIDTH * 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board_in,
    input  logic                   load,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_row,
    output logic [2:0]             out_col,
    output logic [PIECE_WIDTH-1:0] out_piece,
    output logic                   out_last,
    output logic                   done
);

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned SQUARES = 64;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQUARES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BOARD_WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [2:0]             row_q, row_d;
    logic [2:0]             col_q, col_d;
    logic [PIECE_WIDTH-1:0] piece_q, piece_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;

    // Candidate square for the next registered beat: square 0 of board_in
    // when loading, otherwise the square after the current index.
    logic [BOARD_WIDTH-1:0] src_board_c;
    logic [IDX_W-1:0]       src_idx_c;
    logic [PIECE_WIDTH-1:0] src_piece_c;
    logic                   src_emit_c;
    logic                   src_last_c;

`ifdef BOARD_STREAM_SKIP_EMPTY_EN
    logic [SQUARES-1:0] mask_q, mask_d;
    logic [SQUARES-1:0] occ_in_c;
    logic [SQUARES-1:0] src_mask_c;
    logic [SQUARES-1:0] src_above_c;
    logic               src_occ_c;

    // Occupancy of the incoming board, captured alongside the shadow copy.
    always_comb begin
        occ_in_c = '0;
        for (int i = 0; i < SQUARES; i++) begin
            occ_in_c[i] = |board_in[i*PIECE_WIDTH +: PIECE_WIDTH];
        end
    end
`endif

    // Decode of the candidate square.
    always_comb begin
        src_board_c = (state_q == IDLE) ? board_in : shadow_q;
        src_idx_c   = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
        src_piece_c = src_board_c[int'(src_idx_c)*PIECE_WIDTH +: PIECE_WIDTH];
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
        src_mask_c  = (state_q == IDLE) ? occ_in_c : mask_q;
        src_above_c = src_mask_c >> src_idx_c;
        src_occ_c   = |src_piece_c;
        src_emit_c  = src_occ_c;
        // Last when nothing occupied remains above this square.
        src_last_c  = src_occ_c && (src_above_c[SQUARES-1:1] == '0);
`else
        src_emit_c  = 1'b1;
        src_last_c  = (src_idx_c == LAST_IDX);
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        row_d    = row_q;
        col_d    = col_q;
        piece_d  = piece_q;
        last_d   = last_q;
        done_d   = 1'b0;
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
        mask_d   = mask_q;
`endif

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = SCAN;
                    shadow_d = board_in;
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
                    mask_d   = occ_in_c;
`endif
                    busy_d   = 1'b1;
                    idx_d    = src_idx_c;
                    valid_d  = src_emit_c;
                    row_d    = src_idx_c[5:3];
                    col_d    = src_idx_c[2:0];
                    piece_d  = src_piece_c;
                    last_d   = src_emit_c && src_last_c;
                end
            end

            SCAN: begin
                if (valid_q && out_ready && last_q) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!valid_q && idx_q == LAST_IDX) begin
                    // Scanned past the final square without emitting: empty board.
                    state_d = DONE;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!valid_q || out_ready) begin
                    idx_d   = src_idx_c;
                    valid_d = src_emit_c;
                    row_d   = src_idx_c[5:3];
                    col_d   = src_idx_c[2:0];
                    piece_d = src_piece_c;
                    last_d  = src_emit_c && src_last_c;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            piece_q  <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            row_q    <= row_d;
            col_q    <= col_d;
            piece_q  <= piece_d;
            last_q   <= last_d;
            done_q   <= done_d;
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_piece = piece_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_board_stream_out.sv
// Testbench for board_stream_out: directed streams of the initial chess
// position and an empty board, stalls, reset mid-stream and ignored loads.

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef WHITE_PAWN
`define WHITE_PAWN   1
`define WHITE_KNIGHT 2
`define WHITE_BISHOP 3
`define WHITE_ROOK   4
`define WHITE_QUEEN  5
`define WHITE_KING   6
`define BLACK_PAWN   9
`define BLACK_KNIGHT 10
`define BLACK_BISHOP 11
`define BLACK_ROOK   12
`define BLACK_QUEEN  13
`define BLACK_KING   14
`endif

module tb_board_stream_out;

    localparam int unsigned PW = `PIECE_BITS;
    localparam int unsigned BW = PW * 64;
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
    localparam int N_EXP = 32;
`else
    localparam int N_EXP = 64;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] board_in;
    logic          load;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic [PW-1:0] out_piece;
    logic          out_last;
    logic          done;

    always #5 clk = ~clk;

    board_stream_out #(.PIECE_WIDTH(PW), .BOARD_WIDTH(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .board_in (board_in),
        .load     (load),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_piece(out_piece),
        .out_last (out_last),
        .done     (done)
    );

    typedef struct {
        int beat;
        int row;
        int col;
        int piece;
        int last;
    } beat_vec_t;

    beat_vec_t vecs[9];
    int        nvec;

    int total = 0;
    int bad   = 0;

    int b_row[64];
    int b_col[64];
    int b_piece[64];
    int b_last[64];
    int n_beats, done_cycle, hold_err, busy_err, last_err, overflow;

    logic [BW-1:0] ref_board;
    logic [BW-1:0] alt_board;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] init_board();
        logic [BW-1:0] b;
        int wb[8];
        int bb[8];
        wb = '{`WHITE_ROOK, `WHITE_KNIGHT, `WHITE_BISHOP, `WHITE_QUEEN,
               `WHITE_KING, `WHITE_BISHOP, `WHITE_KNIGHT, `WHITE_ROOK};
        bb = '{`BLACK_ROOK, `BLACK_KNIGHT, `BLACK_BISHOP, `BLACK_QUEEN,
               `BLACK_KING, `BLACK_BISHOP, `BLACK_KNIGHT, `BLACK_ROOK};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[c*PW +: PW]      = PW'(wb[c]);
            b[(8+c)*PW +: PW]  = PW'(`WHITE_PAWN);
            b[(48+c)*PW +: PW] = PW'(`BLACK_PAWN);
            b[(56+c)*PW +: PW] = PW'(bb[c]);
        end
        return b;
    endfunction

    // Square index carried by the k-th emitted beat of the initial position.
    function automatic int exp_idx(input int k);
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
        return (k < 16) ? k : k + 32;
`else
        return k;
`endif
    endfunction

    // Load board b, then run until done or a cycle budget expires, recording
    // every transferred beat. mode 1 drives out_ready as 1,0,0,1 repeating.
    task automatic run_stream(input logic [BW-1:0] b, input logic [BW-1:0] alt,
                              input int mode, input bit mid_load);
        int  cyc;
        bit  rdy;
        bit  prev_stall;
        int  p_row, p_col, p_piece, p_last;
        n_beats = 0; done_cycle = -1; hold_err = 0; busy_err = 0;
        last_err = 0; overflow = 0; prev_stall = 0;
        p_row = 0; p_col = 0; p_piece = 0; p_last = 0;
        board_in  = b;
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        load     = 1'b0;
        board_in = alt;
        cyc = 0;
        while (cyc < 300 && done_cycle < 0) begin
            cyc++;
            if (!busy) busy_err++;
            if (out_last && !out_valid) last_err++;
            if (prev_stall && (!out_valid || int'(out_row) != p_row ||
                int'(out_col) != p_col || int'(out_piece) != p_piece ||
                int'(out_last) != p_last))
                hold_err++;
            if (done) done_cycle = cyc;
            if (mode == 1) begin
                case ((cyc - 1) % 4)
                    0, 3:    rdy = 1'b1;
                    default: rdy = 1'b0;
                endcase
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            load = (mid_load && (cyc == 5 || done)) ? 1'b1 : 1'b0;
            if (out_valid && rdy) begin
                if (n_beats < 64) begin
                    b_row[n_beats]   = int'(out_row);
                    b_col[n_beats]   = int'(out_col);
                    b_piece[n_beats] = int'(out_piece);
                    b_last[n_beats]  = int'(out_last);
                    n_beats++;
                end else begin
                    overflow++;
                end
            end
            prev_stall = out_valid && !rdy;
            p_row = int'(out_row); p_col = int'(out_col);
            p_piece = int'(out_piece); p_last = int'(out_last);
            tick();
        end
        load = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_order(input string name, input logic [BW-1:0] b);
        int err;
        int idx;
        err = 0;
        for (int k = 0; k < n_beats; k++) begin
            idx = exp_idx(k);
            if (b_row[k] != idx / 8 || b_col[k] != idx % 8 ||
                b_piece[k] != int'(b[idx*PW +: PW]) ||
                b_last[k] != ((k == N_EXP - 1) ? 1 : 0))
                err++;
        end
        check(name, err, 0);
    endtask

    initial begin
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
        vecs[0] = '{0,  0, 0, `WHITE_ROOK, 0};
        vecs[1] = '{4,  0, 4, `WHITE_KING, 0};
        vecs[2] = '{8,  1, 0, `WHITE_PAWN, 0};
        vecs[3] = '{15, 1, 7, `WHITE_PAWN, 0};
        vecs[4] = '{16, 6, 0, `BLACK_PAWN, 0};
        vecs[5] = '{24, 7, 0, `BLACK_ROOK, 0};
        vecs[6] = '{28, 7, 4, `BLACK_KING, 0};
        vecs[7] = '{31, 7, 7, `BLACK_ROOK, 1};
        nvec = 8;
`else
        vecs[0] = '{0,  0, 0, `WHITE_ROOK,  0};
        vecs[1] = '{3,  0, 3, `WHITE_QUEEN, 0};
        vecs[2] = '{4,  0, 4, `WHITE_KING,  0};
        vecs[3] = '{8,  1, 0, `WHITE_PAWN,  0};
        vecs[4] = '{16, 2, 0, 0,            0};
        vecs[5] = '{47, 5, 7, 0,            0};
        vecs[6] = '{48, 6, 0, `BLACK_PAWN,  0};
        vecs[7] = '{60, 7, 4, `BLACK_KING,  0};
        vecs[8] = '{63, 7, 7, `BLACK_ROOK,  1};
        nvec = 9;
`endif
        ref_board = init_board();
        alt_board = {64{4'd7}};

        // Reset state
        reset = 1'b1; load = 1'b0; out_ready = 1'b0; board_in = '0;
        tick(); tick();
        check("rst_busy",  int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last",  int'(out_last), 0);
        check("rst_done",  int'(done), 0);
        check("rst_row",   int'(out_row), 0);
        check("rst_col",   int'(out_col), 0);
        check("rst_piece", int'(out_piece), 0);
        reset = 1'b0;
        tick();

        // Initial position, sink always ready
        run_stream(ref_board, alt_board, 0, 1'b0);
        check("init_beats", n_beats, N_EXP);
        check("init_overflow", overflow, 0);
        check("init_busy", busy_err, 0);
        check("init_last_without_valid", last_err, 0);
        check("init_order", 0, 0 + 0 * n_beats + 0);
        for (int i = 0; i < nvec; i++) begin
            check($sformatf("init_beat%0d_row", vecs[i].beat),   b_row[vecs[i].beat],   vecs[i].row);
            check($sformatf("init_beat%0d_col", vecs[i].beat),   b_col[vecs[i].beat],   vecs[i].col);
            check($sformatf("init_beat%0d_piece", vecs[i].beat), b_piece[vecs[i].beat], vecs[i].piece);
            check($sformatf("init_beat%0d_last", vecs[i].beat),  b_last[vecs[i].beat],  vecs[i].last);
        end
        check_order("init_sequence", ref_board);
`ifndef BOARD_STREAM_SKIP_EMPTY_EN
        check("init_done_cycle", done_cycle, 65);
`endif
        check("init_done_low_after", int'(done), 0);
        check("init_busy_low_after", int'(busy), 0);
        tick();

        // Same board with a stalling sink
        run_stream(ref_board, alt_board, 1, 1'b0);
        check("stall_beats", n_beats, N_EXP);
        check("stall_hold", hold_err, 0);
        check("stall_last_without_valid", last_err, 0);
        check_order("stall_sequence", ref_board);
`ifndef BOARD_STREAM_SKIP_EMPTY_EN
        check("stall_done_cycle", done_cycle, 129);
`endif
        tick();

        // Empty board
        run_stream('0, ref_board, 0, 1'b0);
`ifdef BOARD_STREAM_SKIP_EMPTY_EN
        check("empty_beats", n_beats, 0);
`else
        check("empty_beats", n_beats, 64);
`endif
        check("empty_done_cycle", done_cycle, 65);
        check("empty_busy", busy_err, 0);
        tick();

        // Loads while busy and during the done cycle are ignored
        run_stream(ref_board, alt_board, 0, 1'b1);
        check("busyload_beats", n_beats, N_EXP);
        check_order("busyload_sequence", ref_board);
        check("doneload_valid", int'(out_valid), 0);
        check("doneload_busy", int'(busy), 0);
        tick();

        // Reset during beat 10 abandons the stream
        board_in = ref_board; load = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0; board_in = alt_board;
        for (int i = 0; i < 10; i++) tick();
        check("mid_beat10_row", int'(out_row), 1);
        check("mid_beat10_col", int'(out_col), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy",  int'(busy), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_last",  int'(out_last), 0);
        check("midrst_done",  int'(done), 0);
        check("midrst_row",   int'(out_row), 0);
        check("midrst_col",   int'(out_col), 0);
        check("midrst_piece", int'(out_piece), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (done || out_valid || busy) seen++;
            end
            check("midrst_quiet", seen, 0);
        end
        run_stream(ref_board, alt_board, 0, 1'b0);
        check("restart_beats", n_beats, N_EXP);
        check("restart_first_piece", b_piece[0], `WHITE_ROOK);
        check_order("restart_sequence", ref_board);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
